serial_parallel_deser: RTL and testbench
========================================

// Module: serial_parallel_deser
// PURPOSE
//  Parametrised serial-to-parallel deserialiser for the serial adder datapath.
//  - Collects LANES bits per enabled cycle into a WIDTH-bit word, in LSB-first or MSB-first order.
//  - Presents each finished word on a registered valid/ready output with a one-word holding register.
//  - Supports frame alignment via start_i, overrun reporting and optional even-parity checking.
// PARAMETERS
//  WIDTH      8  word width in bits; must be a multiple of LANES
//  LANES      1  serial bits accepted per enabled cycle (1, 2, 4 or 8)
//  MSB_FIRST  0  0: first beat lands in the LSBs, shifting right; 1: first beat lands in the MSBs, shifting left
// PORTS
//  clk_i        in   1                  clock; all logic on its rising edge
//  reset_n_i    in   1                  synchronous reset, ACTIVE-HIGH (1 = reset)
//  enable_i     in   1                  serial_i holds a valid beat this cycle
//  start_i      in   1                  frame alignment: restart the word at beat 0
//  serial_i     in   LANES              serial data beat; lane 0 is the earliest bit of the beat
//  data_o       out  WIDTH              assembled word; stable while valid_o=1
//  valid_o      out  1                  data_o holds an unconsumed word
//  ready_i      in   1                  consumer accepts data_o when valid_o & ready_i
//  beat_cnt_o   out  $clog2(BEATS+1)    beats collected in the current word (BEATS = WIDTH/LANES)
//  overrun_o    out  1                  one-cycle pulse: finished word dropped
//  parity_err_o out  1                  parity status for data_o (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (reset_n_i=1 at an edge) has priority over all inputs.
//    - Clears shift_reg, beat_cnt_o, data_o, valid_o, overrun_o and parity_err_o to 0.
//    - Reset mid-word discards the partial word; reset with valid_o=1 discards the held word.
//  - FSM with states FILL and LAST (LAST exists only with SP_PARITY_EN).
//    - In FILL, each edge with enable_i=1 shifts in one beat and increments beat_cnt_o.
//    - enable_i=0 holds all state; serial_i is ignored.
//  - Order within a beat: LSB-first puts lane 0 at the lower bit index; MSB-first puts lane 0 at the higher index.
//  - Word completion is the edge that accepts beat BEATS-1 (or the parity beat). At that edge:
//    - data_o <= assembled word including that beat; valid_o <= 1; beat_cnt_o <= 0.
//    - Latency: the word is visible immediately after the completing edge, with zero bubble.
//    - Back-to-back words are accepted with no idle cycle.
//  - Handshake:
//    - valid_o & ready_i at an edge consumes the word; valid_o falls unless a new word completes at the same edge.
//    - Completion and consume at the same edge: the new word loads and valid_o stays 1.
//    - ready_i while valid_o=0 has no effect.
//  - Overrun: a word completes while valid_o=1 and ready_i=0.
//    - The new word is dropped; data_o keeps the old word; overrun_o=1 for exactly one cycle.
//    - The shifter restarts at beat 0.
//  - start_i:
//    - start_i & enable_i: the current beat becomes beat 0 and the partial word is discarded.
//    - start_i without enable_i: beat_cnt_o <= 0 and shift_reg <= 0.
//    - start_i on a completing beat: the beat is taken as beat 0; no completion and no overrun.
//    - start_i never affects data_o or valid_o.
//  - beat_cnt_o wraps from BEATS-1 to 0 and never reaches BEATS.
// CONFIGURATION
//  SP_PARITY_EN defined:
//    - After BEATS data beats the FSM enters LAST and waits for one extra enabled beat.
//    - serial_i[0] of that beat is the even-parity bit; the other lanes are ignored.
//    - Completion happens on the parity beat.
//    - parity_err_o <= (^word) ^ parity_bit, registered with data_o and held with it.
//    - The word is always delivered, even with a parity error.
//    - start_i during LAST discards the word.
//  SP_PARITY_EN undefined: no LAST state; parity_err_o is tied to 0; the port is always present.
// TESTING
//  1. Default params, LSB-first, bits 1,1,1,0,0,0,1,0 with ready_i=1 -> data_o=8'h47, valid_o=1 for 1 cycle after the 8th edge.
//  2. MSB_FIRST=1, same bits -> data_o=8'hE2; LANES=2, WIDTH=8, beats 2'b11,2'b01,2'b00,2'b10 -> data_o=8'h87 in 4 cycles.
//  3. ready_i=0, two full words 8'hA5 then 8'h3C -> data_o stays 8'hA5, overrun_o pulses once at the 16th edge.
//  4. Completion and ready_i=1 at the same edge -> valid_o never drops, second word appears, no overrun.
//  5. After 5 beats, start_i & enable_i then 8 beats -> word built from the last 8 beats only.
//     Reset at beat 3 -> all outputs 0 and beat_cnt_o=0.
//  6. SP_PARITY_EN, word 8'h47 (4 ones) with parity beat 0 -> parity_err_o=0; with parity beat 1 -> parity_err_o=1.
//     valid_o rises after the 9th enabled edge.

Source files
------------

// File: rtl/serial_parallel_deser.sv
// Serial-to-parallel deserialiser for the serial adder datapath.
// Collects LANES bits per enabled beat into a WIDTH-bit word (LSB-first or
// MSB-first) and presents each finished word through a single holding
// register with a valid/ready output.
//
// Optional feature macro: SP_PARITY_EN
//   When defined, each word is followed by one extra parity beat (serial_i[0],
//   even parity). The word completes on that beat and parity_err_o reports
//   (^word) ^ parity_bit alongside data_o. When undefined, parity_err_o is
//   tied to 0.
//
// Output handshake: valid_o high means data_o holds an unconsumed word; the
// word is consumed at any rising edge where valid_o & ready_i. data_o is
// stable while valid_o is high. A word completing while valid_o & !ready_i is
// dropped and signalled by a one-cycle overrun_o pulse.
//
// state_o exposes the FSM state (0 = FILL, 1 = LAST) for observation.

module serial_parallel_deser #(
    parameter int WIDTH     = 8,
    parameter int LANES     = 1,
    parameter int MSB_FIRST = 0,
    localparam int BEATS    = WIDTH / LANES,
    localparam int CNT_W    = $clog2(BEATS + 1)
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             enable_i,
    input  logic             start_i,
    input  logic [LANES-1:0] serial_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [CNT_W-1:0] beat_cnt_o,
    output logic             overrun_o,
    output logic             parity_err_o,
    output logic             state_o
);

    // Count value of the final data beat of a word.
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    // Count after a start beat has been accepted as beat 0.
    localparam logic [CNT_W-1:0] CNT_AFTER_START = (BEATS > 1) ? CNT_W'(1) : '0;

`ifdef SP_PARITY_EN
    typedef enum logic {
        FILL = 1'b0,
        LAST = 1'b1
    } state_t;
`else
    typedef enum logic {
        FILL = 1'b0
    } state_t;
`endif

    state_t           state_q;
    state_t           next_state;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] next_shift;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;
    logic [CNT_W-1:0] next_cnt;
    logic [WIDTH-1:0] next_data;
    logic             next_valid;
    logic             next_overrun;
    logic             complete;
`ifdef SP_PARITY_EN
    logic             parity_bit;
    logic             next_perr;
    logic             perr_q;
`endif

    // Merge one beat into the partial word. LSB-first: beats enter at the top
    // and move right, so the first beat ends in the LSBs with lane 0 lowest.
    // MSB-first: beats enter at the bottom and move left, with lane 0 placed
    // at the higher bit index of the beat.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                  input logic [LANES-1:0] beat);
        logic [LANES-1:0] rev;
        for (int i = 0; i < LANES; i++) begin
            rev[i] = beat[LANES-1-i];
        end
        if (MSB_FIRST != 0) begin
            return (cur << LANES) | WIDTH'(rev);
        end else begin
            return (cur >> LANES) | (WIDTH'(beat) << (WIDTH - LANES));
        end
    endfunction

    assign state_o = state_q;

`ifdef SP_PARITY_EN
    assign parity_err_o = perr_q;
`else
    assign parity_err_o = 1'b0;
`endif

    // Next-state, shifter, counter and output-register logic.
    always_comb begin
        next_state   = state_q;
        next_shift   = shift_reg;
        next_cnt     = beat_cnt_o;
        next_data    = data_o;
        next_valid   = valid_o;
        next_overrun = 1'b0;
        complete     = 1'b0;
        word         = shift_reg;
        shifted      = shift_in(shift_reg, serial_i);
`ifdef SP_PARITY_EN
        parity_bit   = 1'b0;
        next_perr    = perr_q;
`endif

        // Consumption of the held word.
        if (valid_o && ready_i) begin
            next_valid = 1'b0;
        end

        if (start_i) begin
            // Frame realignment: the partial word (or a word waiting for its
            // parity beat) is discarded and never completes.
            next_state = FILL;
            if (enable_i) begin
                next_shift = shift_in('0, serial_i);
                next_cnt   = CNT_AFTER_START;
            end else begin
                next_shift = '0;
                next_cnt   = '0;
            end
        end else if (enable_i) begin
            case (state_q)
`ifdef SP_PARITY_EN
                LAST: begin
                    // Parity beat: word is already fully assembled.
                    complete   = 1'b1;
                    word       = shift_reg;
                    parity_bit = serial_i[0];
                    next_shift = '0;
                    next_state = FILL;
                end
`endif
                default: begin
                    if (beat_cnt_o == LAST_BEAT) begin
                        next_cnt = '0;
`ifdef SP_PARITY_EN
                        next_shift = shifted;
                        next_state = LAST;
`else
                        complete   = 1'b1;
                        word       = shifted;
                        next_shift = '0;
`endif
                    end else begin
                        next_shift = shifted;
                        next_cnt   = beat_cnt_o + 1'b1;
                    end
                end
            endcase
        end

        // Delivery into the holding register, or drop on overrun.
        if (complete) begin
            if (valid_o && !ready_i) begin
                next_overrun = 1'b1;
            end else begin
                next_data  = word;
                next_valid = 1'b1;
`ifdef SP_PARITY_EN
                next_perr  = (^word) ^ parity_bit;
`endif
            end
        end
    end

    // State, shifter, counter and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            state_q    <= FILL;
            shift_reg  <= '0;
            beat_cnt_o <= '0;
            data_o     <= '0;
            valid_o    <= 1'b0;
            overrun_o  <= 1'b0;
        end else begin
            state_q    <= next_state;
            shift_reg  <= next_shift;
            beat_cnt_o <= next_cnt;
            data_o     <= next_data;
            valid_o    <= next_valid;
            overrun_o  <= next_overrun;
        end
    end

`ifdef SP_PARITY_EN
    // Parity status register, loaded together with data_o.
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= next_perr;
        end
    end
`endif

endmodule

// File: tb/tb_serial_parallel_deser.sv
// Directed bench for serial_parallel_deser: default LSB-first instance, an
// MSB-first instance sharing its serial stream, and a 2-lane instance.
// Parity-mode expectations are selected with SP_PARITY_EN.

module tb_serial_parallel_deser;

    logic clk;
    logic rst;
    logic enable;
    logic start;
    logic ready;
    logic serial;
    logic en_l2;
    logic [1:0] serial_l2;

    logic [7:0] data_a, data_m, data_l;
    logic       valid_a, valid_m, valid_l;
    logic [3:0] cnt_a, cnt_m;
    logic [2:0] cnt_l;
    logic       ovr_a, ovr_m, ovr_l;
    logic       perr_a, perr_m, perr_l;
    logic       st_a, st_m, st_l;

    int vectors = 0;
    int miscompares = 0;

    serial_parallel_deser #(.WIDTH(8), .LANES(1), .MSB_FIRST(0)) dut (
        .clk_i(clk), .reset_n_i(rst), .enable_i(enable), .start_i(start),
        .serial_i(serial), .data_o(data_a), .valid_o(valid_a), .ready_i(ready),
        .beat_cnt_o(cnt_a), .overrun_o(ovr_a), .parity_err_o(perr_a), .state_o(st_a)
    );

    serial_parallel_deser #(.WIDTH(8), .LANES(1), .MSB_FIRST(1)) dut_msb (
        .clk_i(clk), .reset_n_i(rst), .enable_i(enable), .start_i(start),
        .serial_i(serial), .data_o(data_m), .valid_o(valid_m), .ready_i(ready),
        .beat_cnt_o(cnt_m), .overrun_o(ovr_m), .parity_err_o(perr_m), .state_o(st_m)
    );

    serial_parallel_deser #(.WIDTH(8), .LANES(2), .MSB_FIRST(0)) dut_l2 (
        .clk_i(clk), .reset_n_i(rst), .enable_i(en_l2), .start_i(start),
        .serial_i(serial_l2), .data_o(data_l), .valid_o(valid_l), .ready_i(ready),
        .beat_cnt_o(cnt_l), .overrun_o(ovr_l), .parity_err_o(perr_l), .state_o(st_l)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enable = 1'b0;
        tick();
    endtask

    task automatic feed_bit(input logic b);
        serial = b;
        enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    // Full word, LSB-first bit order, plus parity beat in parity mode.
    task automatic send_word(input logic [7:0] w, input logic p);
        for (int i = 0; i < 8; i++) feed_bit(w[i]);
`ifdef SP_PARITY_EN
        feed_bit(p);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; start = 1'b0; ready = 1'b0;
        en_l2 = 1'b0; serial = 1'b0; serial_l2 = 2'b00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] w;
        logic [7:0] bits47;
        bits47 = 8'h47;

        // ---- reset state ----
        do_reset();
        chk("rst_data", data_a, 8'h00);
        chk("rst_valid", valid_a, 1'b0);
        chk("rst_cnt", cnt_a, 4'd0);
        chk("rst_ovr", ovr_a, 1'b0);
        chk("rst_perr", perr_a, 1'b0);

        // ---- test 1/2: LSB-first and MSB-first, bits 1,1,1,0,0,0,1,0 ----
        ready = 1'b1;
        feed_bit(1'b1); chk("t1_cnt1", cnt_a, 4'd1);
        feed_bit(1'b1);
        feed_bit(1'b1); chk("t1_cnt3", cnt_a, 4'd3);
        feed_bit(1'b0);
        feed_bit(1'b0);
        feed_bit(1'b0);
        feed_bit(1'b1); chk("t1_cnt7", cnt_a, 4'd7);
        chk("t1_valid_pre", valid_a, 1'b0);
        feed_bit(1'b0);
`ifdef SP_PARITY_EN
        chk("t6_valid_after8", valid_a, 1'b0);
        chk("t6_state_last", st_a, 1'b1);
        chk("t6_cnt_last", cnt_a, 4'd0);
        feed_bit(1'b0);
        chk("t6_perr0", perr_a, 1'b0);
`endif
        chk("t1_valid", valid_a, 1'b1);
        chk("t1_data", data_a, 8'h47);
        chk("t1_cnt_wrap", cnt_a, 4'd0);
        chk("t2_msb_valid", valid_m, 1'b1);
        chk("t2_msb_data", data_m, 8'hE2);
        idle();
        chk("t1_consumed", valid_a, 1'b0);
        chk("t1_data_kept", data_a, 8'h47);

        // ---- test 2b: LANES=2 beats 11,01,00,10 -> 87 ----
        do_reset();
        ready = 1'b1;
        en_l2 = 1'b1;
        serial_l2 = 2'b11; tick();
        serial_l2 = 2'b01; tick();
        chk("t2_l2_cnt2", cnt_l, 3'd2);
        serial_l2 = 2'b00; tick();
        serial_l2 = 2'b10; tick();
`ifdef SP_PARITY_EN
        chk("t2_l2_valid_pre", valid_l, 1'b0);
        serial_l2 = 2'b00; tick();
`endif
        en_l2 = 1'b0;
        chk("t2_l2_valid", valid_l, 1'b1);
        chk("t2_l2_data", data_l, 8'h87);

        // ---- test 3: overrun with ready low ----
        do_reset();
        ready = 1'b0;
        send_word(8'hA5, 1'b0);
        chk("t3_w1_valid", valid_a, 1'b1);
        chk("t3_w1_data", data_a, 8'hA5);
        chk("t3_w1_ovr", ovr_a, 1'b0);
        w = 8'h3C;
        for (int i = 0; i < 7; i++) feed_bit(w[i]);
`ifdef SP_PARITY_EN
        feed_bit(w[7]);
        chk("t3_ovr_pre", ovr_a, 1'b0);
        feed_bit(1'b0);
`else
        chk("t3_ovr_pre", ovr_a, 1'b0);
        feed_bit(w[7]);
`endif
        chk("t3_ovr_pulse", ovr_a, 1'b1);
        chk("t3_data_held", data_a, 8'hA5);
        chk("t3_valid_held", valid_a, 1'b1);
        chk("t3_cnt_restart", cnt_a, 4'd0);
        idle();
        chk("t3_ovr_clear", ovr_a, 1'b0);
        chk("t3_data_held2", data_a, 8'hA5);
        ready = 1'b1;
        idle();
        chk("t3_consumed", valid_a, 1'b0);

        // ---- test 4: completion and consume on the same edge ----
        do_reset();
        ready = 1'b0;
        send_word(8'h47, 1'b0);
        chk("t4_w1_data", data_a, 8'h47);
        w = 8'h3C;
        for (int i = 0; i < 7; i++) feed_bit(w[i]);
        chk("t4_valid_mid", valid_a, 1'b1);
`ifdef SP_PARITY_EN
        feed_bit(w[7]);
        ready = 1'b1;
        feed_bit(1'b0);
`else
        ready = 1'b1;
        feed_bit(w[7]);
`endif
        chk("t4_valid_stay", valid_a, 1'b1);
        chk("t4_data_new", data_a, 8'h3C);
        chk("t4_no_ovr", ovr_a, 1'b0);
        idle();
        chk("t4_consumed", valid_a, 1'b0);

        // ---- test 5: start_i with enable after 5 beats ----
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 5; i++) feed_bit(1'b1);
        chk("t5_cnt5", cnt_a, 4'd5);
        start = 1'b1;
        feed_bit(bits47[0]);
        start = 1'b0;
        chk("t5_cnt_after_start", cnt_a, 4'd1);
        for (int i = 1; i < 8; i++) feed_bit(bits47[i]);
`ifdef SP_PARITY_EN
        feed_bit(1'b0);
`endif
        chk("t5_data", data_a, 8'h47);
        chk("t5_valid", valid_a, 1'b1);
        idle();

        // start_i without enable_i clears the partial word
        feed_bit(1'b1); feed_bit(1'b1); feed_bit(1'b1);
        start = 1'b1;
        idle();
        start = 1'b0;
        chk("t5_start_noen_cnt", cnt_a, 4'd0);
        chk("t5_start_noen_valid", valid_a, 1'b0);
        send_word(8'h3C, 1'b0);
        chk("t5_after_clear_data", data_a, 8'h3C);
        idle();

        // start_i on what would be the completing beat
`ifdef SP_PARITY_EN
        for (int i = 0; i < 8; i++) feed_bit(1'b1);
`else
        for (int i = 0; i < 7; i++) feed_bit(1'b1);
`endif
        start = 1'b1;
        feed_bit(bits47[0]);
        start = 1'b0;
        chk("t5_startc_valid", valid_a, 1'b0);
        chk("t5_startc_ovr", ovr_a, 1'b0);
        chk("t5_startc_cnt", cnt_a, 4'd1);
        chk("t5_startc_data", data_a, 8'h3C);
        for (int i = 1; i < 8; i++) feed_bit(bits47[i]);
`ifdef SP_PARITY_EN
        feed_bit(1'b0);
`endif
        chk("t5_startc_word", data_a, 8'h47);
        idle();

        // reset at beat 3 with a held word
        ready = 1'b0;
        send_word(8'hA5, 1'b0);
        feed_bit(1'b1); feed_bit(1'b0); feed_bit(1'b1);
        chk("t5_cnt3", cnt_a, 4'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_data", data_a, 8'h00);
        chk("t5_rst_valid", valid_a, 1'b0);
        chk("t5_rst_cnt", cnt_a, 4'd0);
        chk("t5_rst_ovr", ovr_a, 1'b0);
        chk("t5_rst_perr", perr_a, 1'b0);

        // ---- test 6: parity status ----
        ready = 1'b1;
`ifdef SP_PARITY_EN
        send_word(8'h47, 1'b1);
        chk("t6_perr1", perr_a, 1'b1);
        chk("t6_perr1_data", data_a, 8'h47);
        chk("t6_perr1_valid", valid_a, 1'b1);
        idle();
        send_word(8'hA5, 1'b0);
        chk("t6_perr_ok", perr_a, 1'b0);
        chk("t6_perr_ok_data", data_a, 8'hA5);
`else
        send_word(8'h01, 1'b1);
        chk("t6_perr_tied", perr_a, 1'b0);
        chk("t6_data_odd", data_a, 8'h01);
`endif
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
